// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit holding the architectural HI/LO registers.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, clears all state
//   MDUControl  operation code from the decoder (1 mult, 2 multu, 3 div, 4 divu,
//               5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 0 and 9..15 are no-ops)
//   A, B        rs / rt operands
//   Start       combinational, a multiply/divide is accepted this cycle
//   Busy        registered, an operation is in flight
//   HI, LO      architectural HI/LO registers
//   MDUOut      combinational mfhi/mflo read data, 0 otherwise
//
// A multiply/divide computes its full result at acceptance and parks it in pending
// registers; HI/LO are only updated when the modelled latency has elapsed.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  logic [0:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  // Arithmetic datapath
  logic [63:0] prod_s, prod_u;
  logic [31:0] divu_b, divu_q, divu_r;
  logic [31:0] mag_a, mag_b, mag_b_safe, sq_mag, sr_mag, divs_q, divs_r;
  logic        b_zero;

  always_comb begin
    // Explicit sign/zero extension so the full 64-bit product is kept.
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};

    b_zero = (B == 32'd0);
    // Divisor forced to 1 on divide by zero; the result is discarded anyway.
    divu_b = b_zero ? 32'd1 : B;
    divu_q = A / divu_b;
    divu_r = A % divu_b;

    // Signed divide via magnitudes; 0x80000000 has magnitude 0x80000000 as unsigned.
    mag_a      = A[31] ? (~A + 32'd1) : A;
    mag_b      = B[31] ? (~B + 32'd1) : B;
    mag_b_safe = b_zero ? 32'd1 : mag_b;
    sq_mag     = mag_a / mag_b_safe;
    sr_mag     = mag_a % mag_b_safe;
    divs_q     = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
    divs_r     = A[31] ? (~sr_mag + 32'd1) : sr_mag;
  end

  assign Start = (state_q == StIdle) && (MDUControl >= OpMult) && (MDUControl <= OpDivu);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (state_q == StIdle) begin
      case (MDUControl)
        OpMult: begin
          {pend_hi_d, pend_lo_d} = prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CYCLES;
          state_d   = StBusy;
        end
        OpMultu: begin
          {pend_hi_d, pend_lo_d} = prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CYCLES;
          state_d   = StBusy;
        end
        OpDiv: begin
          pend_hi_d = divs_r;
          pend_lo_d = divs_q;
          pend_wr_d = !b_zero;
          cnt_d     = DIV_CYCLES;
          state_d   = StBusy;
        end
        OpDivu: begin
          pend_hi_d = divu_r;
          pend_lo_d = divu_q;
          pend_wr_d = !b_zero;
          cnt_d     = DIV_CYCLES;
          state_d   = StBusy;
        end
        OpMthi:  hi_d = A;
        OpMtlo:  lo_d = A;
        default: ;
      endcase
    end else begin
      // Every op code is ignored while busy.
      cnt_d = cnt_q - 32'd1;
      if (cnt_q == 32'd1) begin
        state_d = StIdle;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign Busy = (state_q == StBusy);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    MDUOut = 32'd0;
    if (MDUControl == OpMfhi) MDUOut = hi_q;
    else if (MDUControl == OpMflo) MDUOut = lo_q;
  end

endmodule
